// File: rtl/div_unit_pkg.sv
// Shared encodings for the RV32M divider.
// Op codes, FSM states and the iteration count.
package div_unit_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  localparam int DIV_ITER = 32;

  typedef enum logic [1:0] {
    DIV_ST_IDLE = 2'd0,
    DIV_ST_CALC = 2'd1,
    DIV_ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU.
// One op in flight; special cases skip the iteration loop.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              div_start_i,
  input  logic [1:0]        div_op_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  input  logic              flush_i,
  output logic              div_res_ready_o,
  output logic [DATA_W-1:0] div_result_o,
  output logic              div_busy_o
);

  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]  LAST    = CNT_W'(DIV_ITER - 1);

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              sel_rem_q, sel_rem_d;
  logic              neg_q_q, neg_q_d;
  logic              neg_r_q, neg_r_d;
  logic              ready_q, ready_d;

  logic              is_signed, s1, s2;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic [DATA_W:0]   rem_sh, diff;
  logic              take;
  logic [DATA_W-1:0] rem_n, quo_n, q_fix, r_fix;

  always_comb begin
    is_signed = ~div_op_i[0];
    s1        = is_signed & dividend_i[DATA_W-1];
    s2        = is_signed & divisor_i[DATA_W-1];
    a_mag     = s1 ? -dividend_i : dividend_i;
    b_mag     = s2 ? -divisor_i : divisor_i;

    // Trial subtract one bit wider so the borrow shows the sign.
    rem_sh = {rem_q, quo_q[DATA_W-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    take   = ~diff[DATA_W];
    rem_n  = take ? diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
    quo_n  = {quo_q[DATA_W-2:0], take};
    q_fix  = neg_q_q ? -quo_n : quo_n;
    r_fix  = neg_r_q ? -rem_n : rem_n;

    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    res_d     = res_q;
    result_d  = result_q;
    sel_rem_d = sel_rem_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    ready_d   = 1'b0;

    unique case (state_q)
      DIV_ST_IDLE: begin
        if (div_start_i && !flush_i) begin
          sel_rem_d = div_op_i[1];
          if (divisor_i == '0) begin
            res_d   = div_op_i[1] ? dividend_i : '1;
            state_d = DIV_ST_DONE;
          end else if (is_signed && dividend_i == MIN_NEG
                       && divisor_i == '1) begin
            res_d   = div_op_i[1] ? '0 : MIN_NEG;
            state_d = DIV_ST_DONE;
          end else begin
            quo_d   = a_mag;
            dvs_d   = b_mag;
            rem_d   = '0;
            cnt_d   = '0;
            neg_q_d = s1 ^ s2;
            neg_r_d = s1;
            state_d = DIV_ST_CALC;
          end
        end
      end
      DIV_ST_CALC: begin
        rem_d = rem_n;
        quo_d = quo_n;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          res_d   = sel_rem_q ? r_fix : q_fix;
          state_d = DIV_ST_DONE;
        end
      end
      DIV_ST_DONE: begin
        ready_d  = 1'b1;
        result_d = res_q;
        state_d  = DIV_ST_IDLE;
      end
      default: state_d = DIV_ST_IDLE;
    endcase

    if (flush_i) state_d = DIV_ST_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= DIV_ST_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      res_q     <= '0;
      result_q  <= '0;
      sel_rem_q <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      res_q     <= res_d;
      result_q  <= result_d;
      sel_rem_q <= sel_rem_d;
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
      ready_q   <= ready_d;
    end
  end

  assign div_res_ready_o = ready_q;
  assign div_result_o    = result_q;
  assign div_busy_o      = (state_q != DIV_ST_IDLE);

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit.
// Driver pushes expected result and due cycle; monitor pops on ready.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        ready;
  logic [31:0] result;
  logic        busy;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  int   pulses = 0;
  int   last_rdy = -1;
  int   prev_rdy_cyc = -1;
  logic prev_rdy = 1'b0;

  div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .div_start_i(start),
    .div_op_i(op),
    .dividend_i(a),
    .divisor_i(b),
    .flush_i(flush),
    .div_res_ready_o(ready),
    .div_result_o(result),
    .div_busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (prev_rdy) begin
      checks++;
      if (ready !== 1'b0) begin
        fails++;
        $display("FAIL pulse_width: ready=%b want 0 at cyc %0d",
                 ready, cyc);
      end
    end
    prev_rdy = (ready === 1'b1);
    if (ready === 1'b1) begin
      pulses++;
      prev_rdy_cyc = last_rdy;
      last_rdy = cyc;
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_ready: result=%h at cyc %0d",
                 result, cyc);
      end else begin
        e = sb.pop_front();
        checks += 2;
        if (result !== e.res) begin
          fails++;
          $display("FAIL result: got %h want %h", result, e.res);
        end
        if (cyc != e.due) begin
          fails++;
          $display("FAIL latency: ready cyc %0d want %0d", cyc, e.due);
        end
      end
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] r,
                        input int lat);
    bit got;
    exp_t e;
    e.res = r;
    e.due = cyc + lat;
    sb.push_back(e);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      if (ready === 1'b1) got = 1'b1;
    end
    start = 1'b0;
    if (!got) begin
      checks++;
      fails++;
      $display("FAIL timeout: op %b %h/%h", o, x, y);
    end
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  initial begin
    int p0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 34);
    run_op(DIV_OP_REMU, 32'd100, 32'd7, 32'd2, 34);
    run_op(DIV_OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
    run_op(DIV_OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
    run_op(DIV_OP_DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 34);

    run_op(DIV_OP_DIV, 32'h12345678, 32'd0, 32'hFFFFFFFF, 2);
    run_op(DIV_OP_DIVU, 32'h12345678, 32'd0, 32'hFFFFFFFF, 2);
    run_op(DIV_OP_REM, 32'h12345678, 32'd0, 32'h12345678, 2);
    run_op(DIV_OP_REMU, 32'h12345678, 32'd0, 32'h12345678, 2);

    run_op(DIV_OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2);
    run_op(DIV_OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2);

    // Flush during iteration 10.
    p0 = pulses;
    op = DIV_OP_DIVU;
    a = 32'hDEADBEEF;
    b = 32'd3;
    start = 1'b1;
    repeat (11) @(negedge clk);
    chk("busy_calc", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    start = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    chk("flush_no_pulse", pulses - p0, 32'd0);
    run_op(DIV_OP_DIVU, 32'd9, 32'd3, 32'd3, 34);

    // Reset in the middle of CALC.
    p0 = pulses;
    op = DIV_OP_DIVU;
    a = 32'd1000;
    b = 32'd7;
    start = 1'b1;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", {31'd0, ready}, 32'd0);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("rst_no_pulse", pulses - p0, 32'd0);

    run_op(DIV_OP_DIVU, 32'd1000, 32'd10, 32'd100, 34);
    run_op(DIV_OP_DIVU, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 34);
    chk("b2b_gap", last_rdy - prev_rdy_cyc, 32'd35);

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: cyc %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
